// File: rtl/halt_console.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | halt_console: captures the CPU debug word on halt, shows it on 16 LEDs,  |
// | and debounces a button into a one-cycle continue pulse.                  |
// | Optional macro HALT_CONSOLE_AUTOSTEP_EN: auto-continue after AUTO_DELAY. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module halt_console #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_DELAY      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] debug,
  input  logic        halted,
  input  logic        btn_raw,
  input  logic        sel_hi,
  output logic        cont,
  output logic [15:0] led,
  output logic        hold,
  output logic [7:0]  capture_cnt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   snap;
  logic          s1;
  logic          s2;
  logic          db;
  logic          db_q;
  logic [DW-1:0] dcnt;
  logic          press;
  logic          auto_fire;

  // The level only changes after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      dcnt <= '0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        db   <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_q;

`ifdef HALT_CONSOLE_AUTOSTEP_EN
  localparam logic [15:0] AUTO_LAST = 16'(AUTO_DELAY - 1);
  logic [15:0] acnt;

  // Held at zero outside HALTED so it starts from zero on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acnt <= '0;
    end else if (state != ST_HALTED) begin
      acnt <= '0;
    end else begin
      acnt <= acnt + 16'd1;
    end
  end

  assign auto_fire = (acnt == AUTO_LAST);
`else
  assign auto_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      snap        <= '0;
      capture_cnt <= '0;
      cont        <= 1'b0;
      hold        <= 1'b0;
    end else begin
      cont <= 1'b0;
      case (state)
        ST_RUN: begin
          if (halted) begin
            snap        <= debug;
            capture_cnt <= capture_cnt + 8'd1;
            state       <= ST_HALTED;
            hold        <= 1'b1;
          end
        end
        ST_HALTED: begin
          // A CPU resumed by other means takes priority over any continue.
          if (!halted) begin
            state <= ST_RUN;
            hold  <= 1'b0;
          end else if (press || auto_fire) begin
            cont  <= 1'b1;
            state <= ST_RELEASE;
            hold  <= 1'b0;
          end
        end
        ST_RELEASE: begin
          if (!halted) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
          hold  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= sel_hi ? snap[31:16] : snap[15:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_halt_console.sv
`default_nettype none
// tb_halt_console: directed self-checking bench for halt_console (default build).
module tb_halt_console;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] debug;
  logic        halted;
  logic        btn_raw;
  logic        sel_hi;
  logic        cont;
  logic [15:0] led;
  logic        hold;
  logic [7:0]  capture_cnt;

  int checks = 0;
  int errors = 0;

  halt_console #(.DEBOUNCE_CYCLES(4), .AUTO_DELAY(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .debug       (debug),
    .halted      (halted),
    .btn_raw     (btn_raw),
    .sel_hi      (sel_hi),
    .cont        (cont),
    .led         (led),
    .hold        (hold),
    .capture_cnt (capture_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the button for hi cycles, release for lo cycles, counting cont-high cycles.
  task automatic press_watch(input int hi, input int lo, output int pulses);
    pulses  = 0;
    btn_raw = 1'b1;
    for (int k = 0; k < hi; k++) begin
      @(negedge clk);
      if (cont) pulses++;
    end
    btn_raw = 1'b0;
    for (int k = 0; k < lo; k++) begin
      @(negedge clk);
      if (cont) pulses++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    int at;
    int tot;
    logic [4:0] bounce;

    rst = 1'b1; debug = '0; halted = 1'b0; btn_raw = 1'b0; sel_hi = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle", {6'd0, cont, hold, led, capture_cnt}, 32'd0);
    end

    // Capture of DEADBEEF and display select
    debug  = 32'hDEADBEEF;
    halted = 1'b1;
    @(negedge clk);
    check("cap_hold", hold, 1);
    check("cap_cnt1", capture_cnt, 1);
    @(negedge clk);
    check("led_hi", led, 32'hDEAD);
    sel_hi = 1'b0;
    @(negedge clk);
    check("led_lo", led, 32'hBEEF);
    debug = 32'h12345678;

    // Bouncy press in HALTED: 1,0,1,1,0 then held high
    bounce = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      btn_raw = bounce[i];
      @(negedge clk);
      if (cont) check("bounce_early_cont", cont, 0);
    end
    btn_raw = 1'b1;
    p = 0; at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cont) begin
        p++;
        at = k;
      end
    end
    check("bounce_pulses", p, 1);
    check("bounce_latency", at, 6);
    check("release_hold", hold, 0);
    halted  = 1'b0;
    btn_raw = 1'b0;
    @(negedge clk);
    check("run_hold", hold, 0);
    repeat (8) @(negedge clk);

    // CPU resumed by other means while HALTED
    halted = 1'b1;
    @(negedge clk);
    check("halt2_hold", hold, 1);
    check("halt2_cnt", capture_cnt, 2);
    check("led_snap2", {16'd0, led}, 32'hBEEF);
    halted = 1'b0;
    @(negedge clk);
    check("halt2_led", led, 32'h5678);
    check("resume_hold", hold, 0);
    check("resume_cont", cont, 0);
    @(negedge clk);

    // Press in RUN is discarded and never queued
    press_watch(12, 8, p);
    check("run_press", p, 0);
    halted = 1'b1;
    p = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cont) p++;
    end
    check("no_queued_press", p, 0);
    check("halt3_hold", hold, 1);
    check("halt3_cnt", capture_cnt, 3);
    press_watch(12, 8, p);
    check("fresh_press", p, 1);
    halted = 1'b0;
    repeat (2) @(negedge clk);

    // Wrap capture_cnt through 256 halts
    tot = 0;
    for (int i = 0; i < 253; i++) begin
      halted = 1'b1;
      repeat (2) @(negedge clk);
      press_watch(12, 8, p);
      tot += p;
      halted = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("wrap_pulses", tot, 253);
    check("wrap_cnt", capture_cnt, 0);
    check("wrap_hold", hold, 0);

    // Reset mid-debounce in HALTED
    halted = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_cnt", capture_cnt, 1);
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst", {6'd0, cont, hold, led, capture_cnt}, 32'd0);
    halted = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cont) p++;
    end
    check("post_rst_cont", p, 0);
    check("post_rst_cnt", capture_cnt, 0);
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);

    // No button: continue only from autostep when enabled
    halted = 1'b1;
    p = 0; at = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cont) begin
        p++;
        at = k;
      end
    end
`ifdef HALT_CONSOLE_AUTOSTEP_EN
    check("auto_pulses", p, 1);
    check("auto_latency", at, 8);
`else
    check("no_auto_pulses", p, 0);
    check("no_auto_hold", hold, 1);
`endif
    check("auto_cnt", capture_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/halt_console.md
# halt_console

Board-side front end for the CPU's halt/continue debug port. It watches the CPU halted flag and captures the 32-bit `debug` word at each halt. It shows that word on 16 LEDs, one half at a time, and turns a bouncy pushbutton into the single-cycle `continue` pulse that resumes the CPU. It sits between the CPU instance and the FPGA top-level pins, driving the CPU's `continue` input and consuming its `debug` output.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required before the debounced button level changes. Board builds override it with a large value; the default suits simulation.
- `AUTO_DELAY`, default 8: cycles spent in HALTED before an automatic continue. Used only with `HALT_CONSOLE_AUTOSTEP_EN`.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock, the same clock as the CPU.
- `rst`  in  1  asynchronous, active-high reset.
- `debug`  in  32  CPU debug word, synchronous to `clk`.
- `halted`  in  1  CPU halted flag, synchronous to `clk` (no synchronizer).
- `btn_raw`  in  1  raw pushbutton, asynchronous and bouncy.
- `sel_hi`  in  1  display select: 1 shows `snap[31:16]`, 0 shows `snap[15:0]`.
- `cont`  out  1  one-cycle continue pulse to the CPU.
- `led`  out  16  selected half of the captured word.
- `hold`  out  1  high while in HALTED.
- `capture_cnt`  out  8  number of halts captured, wraps.

## Operation
- Button path:
  - 2-flop synchronizer `btn_raw` -> `s2`.
  - Counter `dcnt` clears whenever `s2 == db`. Otherwise it increments.
  - On the edge where `dcnt` would reach `DEBOUNCE_CYCLES`, `db <= s2` and `dcnt <= 0`.
  - `press = db & ~db_q`, where `db_q` is `db` delayed one cycle.
- FSM states:
  - RUN, reset state:
    - If `halted == 1`: `snap <= debug`, `capture_cnt <= capture_cnt + 1` (255 -> 0), go to HALTED.
    - A press in RUN is discarded; it is never queued.
  - HALTED:
    - If `halted == 0` (CPU resumed by other means): go to RUN, no `cont`.
    - Else if `press`: `cont <= 1` for exactly one cycle, go to RELEASE.
  - RELEASE:
    - Wait for `halted == 0`, then go to RUN.
    - Further presses are ignored.
    - If the CPU re-halts without ever dropping `halted`, the block stays in RELEASE.
- Simultaneous events:
  - `halted` rising on the same edge as `press` while in RUN: capture happens and the press is lost.
  - In HALTED, `halted == 0` has priority over `press`.
- Outputs:
  - `hold` = registered (state == HALTED).
  - `led <= sel_hi ? snap[31:16] : snap[15:0]`, registered.
- Reset at any point, including mid-debounce or in RELEASE:
  - State RUN; `snap`, `capture_cnt`, `dcnt`, `db`, `db_q`, synchronizer flops, `cont`, `hold`, `led` all 0.
  - Behaviour resumes on the first clock edge after `rst` falls.

## Timing
- All outputs are registered. Reset values are 0 for `cont`, `hold`, `led` and `capture_cnt`.
- Halt capture: if `halted` is sampled 1 in RUN at edge n, then after edge n `snap`, `capture_cnt` and `hold` are updated, and after edge n+1 `led` shows the new word.
- Button latency: if `btn_raw` is stable at 1 from sampling edge 0, then:
  - `db` rises at edge `DEBOUNCE_CYCLES + 1`.
  - `cont` is high for the cycle after edge `DEBOUNCE_CYCLES + 2`, i.e. edge 6 with the default.
- A bounce that returns to the old level before the count completes resets `dcnt`; no level change occurs.
- `sel_hi` change: `led` updates after one edge.

## Configuration
- `HALT_CONSOLE_AUTOSTEP_EN`:
  - Defined: an 8-bit-or-wider counter clears on entry to HALTED and increments each HALTED cycle. When it reaches `AUTO_DELAY`, the block issues `cont` and goes to RELEASE exactly as a press would. A press reaching HALTED first wins.
  - Undefined: `cont` is produced only by a button press; the counter logic and `AUTO_DELAY` are unused.

## Test plan
- Reset with `halted = 0`, `btn_raw = 0` -> `cont`, `hold`, `led`, `capture_cnt` all 0 for 20 cycles.
- `debug = 32'hDEADBEEF`, `halted` rises at edge n:
  - after edge n: `hold = 1`, `capture_cnt = 1`;
  - after edge n+1, with `sel_hi = 1`: `led = 16'hDEAD`;
  - toggle `sel_hi` to 0: `led = 16'hBEEF` one cycle later.
- In HALTED, `btn_raw` goes 1 with bounce 1,0,1,1,0 then held at 1 -> exactly one `cont` pulse, 6 edges after the final rising sample; the block then drops `halted`, state RUN, `hold = 0`.
- Press while in RUN -> no `cont`; a later halt needs a fresh press.
- 256 halt/continue cycles -> `capture_cnt` wraps to 0. Assert `rst` mid-debounce in HALTED -> all outputs 0 immediately, no `cont` after release.
- With `HALT_CONSOLE_AUTOSTEP_EN`, `AUTO_DELAY = 8`, no button -> `cont` pulses 8 cycles after HALTED entry. Without the macro -> no `cont` for 100 cycles.
